// File: rtl/spi_flash_front.sv
// spi_flash_front: SPI-mode-0 flash command decoder driving burst write requests and an opcode log
module spi_flash_front (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_active,
    output logic        spi_cmd_write,
    output logic        spi_write_type,
    output logic [21:0] spi_write_addr,
    output logic [12:0] spi_write_len,
    input  logic        spi_write_done,
    output logic        log_strobe,
    output logic [7:0]  log_val
);
    localparam logic [23:0] JEDEC_ID = 24'hEF4018;
    typedef enum logic [1:0] {IDLE, ACCEPT, DONE} state_t;
    state_t      state;
    logic [1:0]  sck_s, cs_s, mosi_s;
    logic        sck_h, cs_h;
    logic [2:0]  bit_cnt, byte_cnt;
    logic [6:0]  sr;
    logic [7:0]  cmd, tx_sr, rx, cur_op, resp;
    logic [23:0] addr;
    logic [8:0]  dcnt;
    logic        wel, wip;
    logic        sck_rise, sck_fall, cs_rise, cs_fall, byte_done, op_done, allowed;
    logic        erase_ok, prog_ok, commit, pop;
    logic [9:0]  ptot;
    logic [6:0]  nb;
    logic [21:0] c_addr;
    logic [12:0] c_len;
    logic [7:0]  f0, f1;
    logic [1:0]  fcnt;
    logic [2:0]  lcnt;
    logic        lbusy;

    // Pin edges, byte completion, response selection and commit decoding
    always_comb begin
        sck_rise  = sck_s[1] & ~sck_h;
        sck_fall  = ~sck_s[1] & sck_h;
        cs_fall   = ~cs_s[1] & cs_h;
        cs_rise   = cs_s[1] & ~cs_h;
        byte_done = sck_rise & ~cs_s[1] & (bit_cnt == 3'd7);
        op_done   = byte_done & (byte_cnt == 3'd0);
        rx        = {sr, mosi_s[1]};
        allowed   = ~wip | (rx == 8'h05) | (rx == 8'h9F);
        cur_op    = op_done ? (allowed ? rx : 8'h00) : cmd;
        resp      = cur_op == 8'h9F ? (byte_cnt == 3'd0 ? JEDEC_ID[23:16] :
                                       byte_cnt == 3'd1 ? JEDEC_ID[15:8] :
                                       byte_cnt == 3'd2 ? JEDEC_ID[7:0] : 8'hFF) :
                    cur_op == 8'h05 ? {6'b0, wel, wip} : 8'hFF;
        erase_ok  = (cmd == 8'h20 || cmd == 8'hD8) && byte_cnt == 3'd4;
        prog_ok   = cmd == 8'h02 && dcnt != 9'd0;
        commit    = cs_rise & (bit_cnt == 3'd0) & wel & (state == IDLE) & (erase_ok | prog_ok);
        ptot      = {7'b0, addr[2:0]} + {1'b0, dcnt} + 10'd7;
        nb        = ptot[9:3];
        c_addr    = cmd == 8'h20 ? {1'b0, addr[23:12], 9'b0} :
                    cmd == 8'hD8 ? {1'b0, addr[23:16], 13'b0} : {1'b0, addr[23:3]};
        c_len     = cmd == 8'h20 ? 13'd511 :
                    cmd == 8'hD8 ? 13'd8191 :
                    nb > 7'd32 ? 13'd31 : {6'b0, nb - 7'd1};
        pop       = ~lbusy & (fcnt != 2'd0);
    end

    // Two-stage pin synchronisers plus edge-detect history; idle levels avoid spurious edges after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s      <= 2'b00;
            cs_s       <= 2'b11;
            mosi_s     <= 2'b00;
            sck_h      <= 1'b0;
            cs_h       <= 1'b1;
            spi_active <= 1'b0;
        end else begin
            sck_s      <= {sck_s[0], spi_sck};
            cs_s       <= {cs_s[0], spi_cs_n};
            mosi_s     <= {mosi_s[0], spi_mosi};
            sck_h      <= sck_s[1];
            cs_h       <= cs_s[1];
            spi_active <= ~cs_s[1];
        end
    end

    // Byte framing on SCK rise, opcode/address/data-count capture, MISO shifting on SCK fall
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            sr       <= 7'd0;
            cmd      <= 8'h00;
            addr     <= 24'd0;
            dcnt     <= 9'd0;
            tx_sr    <= 8'hFF;
            spi_miso <= 1'b1;
        end else begin
            if (cs_s[1]) spi_miso <= 1'b1;
            else if (sck_fall) begin
                spi_miso <= tx_sr[7];
                tx_sr    <= {tx_sr[6:0], 1'b1};
            end
            if (cs_fall) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 3'd0;
                dcnt     <= 9'd0;
                cmd      <= 8'h00;
                tx_sr    <= 8'hFF;
            end else if (sck_rise && !cs_s[1]) begin
                sr      <= rx[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    tx_sr <= resp;
                    if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
                    if (byte_cnt == 3'd0) cmd <= allowed ? rx : 8'h00;
                    else if (byte_cnt < 3'd4) addr <= {addr[15:0], rx};
                    else if (dcnt != 9'h1FF) dcnt <= dcnt + 9'd1;
                end
            end
        end
    end

    // Request handshake with the glue stage; owns WEL and WIP
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            spi_cmd_write  <= 1'b0;
            spi_write_type <= 1'b0;
            spi_write_addr <= 22'd0;
            spi_write_len  <= 13'd0;
            wip            <= 1'b0;
            wel            <= 1'b0;
        end else begin
            if (op_done && allowed && rx == 8'h06) wel <= 1'b1;
            else if (op_done && allowed && rx == 8'h04) wel <= 1'b0;
            if (commit) begin
                spi_write_type <= cmd != 8'h02;
                spi_write_addr <= c_addr;
                spi_write_len  <= c_len;
                spi_cmd_write  <= 1'b1;
                wip            <= 1'b1;
                state          <= ACCEPT;
            end else if (state == ACCEPT && !spi_write_done) state <= DONE;
            else if (state == DONE && spi_write_done) begin
                spi_cmd_write <= 1'b0;
                wip           <= 1'b0;
                wel           <= 1'b0;
                state         <= IDLE;
            end
        end
    end

    // Opcode log: 2-deep queue feeding a 4-clk-high, 5-clk-low strobe; newest opcode dropped when full
    always_ff @(posedge clk) begin
        if (reset) begin
            f0         <= 8'h00;
            f1         <= 8'h00;
            fcnt       <= 2'd0;
            lcnt       <= 3'd0;
            lbusy      <= 1'b0;
            log_strobe <= 1'b0;
            log_val    <= 8'h00;
        end else begin
            if (pop) begin
                log_val    <= f0;
                log_strobe <= 1'b1;
                lcnt       <= 3'd0;
                lbusy      <= 1'b1;
            end else if (lbusy) begin
                lcnt <= lcnt + 3'd1;
                if (lcnt == 3'd3) log_strobe <= 1'b0;
                if (lcnt == 3'd7) lbusy <= 1'b0;
            end
            if (op_done && pop) begin
                if (fcnt == 2'd2) begin
                    f0 <= f1;
                    f1 <= rx;
                end else f0 <= rx;
            end else if (pop) begin
                f0   <= f1;
                fcnt <= fcnt - 2'd1;
            end else if (op_done && fcnt != 2'd2) begin
                if (fcnt == 2'd0) f0 <= rx;
                else f1 <= rx;
                fcnt <= fcnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_front.sv
// tb_spi_flash_front: scoreboard bench for the SPI flash front end
module tb_spi_flash_front;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_write_done = 1'b1;
    logic        spi_miso, spi_active, spi_cmd_write, spi_write_type, log_strobe;
    logic [21:0] spi_write_addr;
    logic [12:0] spi_write_len;
    logic [7:0]  log_val;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  miso_q[$];
    logic [7:0]  log_q[$];
    logic [35:0] req_q[$];
    logic [35:0] last_req;
    logic [7:0]  log_e;
    logic        a2, a3, w2, w3;
    logic        prev_strobe = 1'b0;
    int          width = 0;

    spi_flash_front dut (
        .clk(clk),
        .reset(reset),
        .spi_sck(spi_sck),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_active(spi_active),
        .spi_cmd_write(spi_cmd_write),
        .spi_write_type(spi_write_type),
        .spi_write_addr(spi_write_addr),
        .spi_write_len(spi_write_len),
        .spi_write_done(spi_write_done),
        .log_strobe(log_strobe),
        .log_val(log_val)
    );

    always #5 clk = ~clk;

    // Log scoreboard consumer: each strobe pulse pops one expected opcode and must last 4 clk
    always @(negedge clk) begin
        if (log_strobe && !prev_strobe) begin
            tests++;
            if (log_q.size() == 0) begin
                fails++;
                $display("FAIL log_unexpected: strobe with val=%02h, none expected", log_val);
            end else begin
                log_e = log_q.pop_front();
                if (log_val !== log_e) begin
                    fails++;
                    $display("FAIL log_val: got %02h expected %02h", log_val, log_e);
                end
            end
            width = 1;
        end else if (log_strobe) width++;
        else if (prev_strobe) begin
            tests++;
            if (width != 4) begin
                fails++;
                $display("FAIL log_width: got %0d clk expected 4", width);
            end
        end
        prev_strobe = log_strobe;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic [7:0] t, input logic [7:0] e);
        tx_q.push_back(t);
        miso_q.push_back(e);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            #60;
            rx[i] = spi_miso;
            spi_sck = 1'b1;
            #60;
            spi_sck = 1'b0;
        end
    endtask

    // Drives one CS frame from tx_q, comparing each MISO byte against miso_q
    task automatic run_txn(input string name, input int extra);
        logic [7:0] r, e, t;
        int idx;
        idx = 0;
        @(posedge clk);
        #2 spi_cs_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 a2 = spi_active;
        @(posedge clk);
        #1 a3 = spi_active;
        repeat (3) @(posedge clk);
        #2;
        if (tx_q.size() > 0) log_q.push_back(tx_q[0]);
        while (tx_q.size() > 0) begin
            t = tx_q.pop_front();
            spi_byte(t, r);
            e = miso_q.pop_front();
            tests++;
            if (r !== e) begin
                fails++;
                $display("FAIL %s miso byte %0d: got %02h expected %02h", name, idx, r, e);
            end
            idx++;
        end
        for (int i = 0; i < extra; i++) begin
            spi_mosi = 1'b1;
            #60 spi_sck = 1'b1;
            #60 spi_sck = 1'b0;
        end
        #60 spi_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 w2 = spi_cmd_write;
        @(posedge clk);
        #1 w3 = spi_cmd_write;
        repeat (5) @(posedge clk);
    endtask

    // Glue-stage model: pops the expected request, checks it, then runs the done handshake
    task automatic serve_req(input string name);
        int n;
        n = 0;
        #1;
        while (spi_cmd_write !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        last_req = req_q.pop_front();
        tests++;
        if ({spi_cmd_write, spi_write_type} !== {1'b1, last_req[35]}) begin
            fails++;
            $display("FAIL %s req/type: got %b/%b expected 1/%b", name, spi_cmd_write, spi_write_type, last_req[35]);
        end
        tests++;
        if (spi_write_addr !== last_req[34:13]) begin
            fails++;
            $display("FAIL %s addr: got %06h expected %06h", name, spi_write_addr, last_req[34:13]);
        end
        tests++;
        if (spi_write_len !== last_req[12:0]) begin
            fails++;
            $display("FAIL %s len: got %0d expected %0d", name, spi_write_len, last_req[12:0]);
        end
        #1 spi_write_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 tests++;
        if ({spi_cmd_write, spi_write_type, spi_write_addr, spi_write_len} !== {1'b1, last_req}) begin
            fails++;
            $display("FAIL %s hold: got %b %b %06h %0d", name, spi_cmd_write, spi_write_type, spi_write_addr, spi_write_len);
        end
        #1 spi_write_done = 1'b1;
        @(posedge clk);
        #1 tests++;
        if (spi_cmd_write !== 1'b0) begin
            fails++;
            $display("FAIL %s release: cmd_write got %b expected 0", name, spi_cmd_write);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1 tests++;
        if ({spi_miso, spi_active, spi_cmd_write, spi_write_type, log_strobe} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_bits: got %b expected 10000", {spi_miso, spi_active, spi_cmd_write, spi_write_type, log_strobe});
        end
        tests++;
        if (spi_write_addr !== 22'd0 || spi_write_len !== 13'd0) begin
            fails++;
            $display("FAIL reset_addr_len: got %06h/%0d expected 0/0", spi_write_addr, spi_write_len);
        end
        tests++;
        if (log_val !== 8'h00) begin
            fails++;
            $display("FAIL reset_log_val: got %02h expected 00", log_val);
        end
    endtask

    task automatic test_idcode;
        add(8'h9F, 8'hFF);
        add(8'h00, 8'hEF);
        add(8'h00, 8'h40);
        add(8'h00, 8'h18);
        add(8'h00, 8'hFF);
        run_txn("idcode", 0);
        tests++;
        if ({a2, a3} !== 2'b01) begin
            fails++;
            $display("FAIL active_latency: got %b expected 01", {a2, a3});
        end
        tests++;
        if (log_q.size() != 0 || log_val !== 8'h9F) begin
            fails++;
            $display("FAIL idcode_log: pending %0d val %02h expected 0 9F", log_q.size(), log_val);
        end
    endtask

    task automatic test_erase_sector;
        add(8'h06, 8'hFF);
        run_txn("wren", 0);
        req_q.push_back({1'b1, 22'h024600, 13'd511});
        add(8'h20, 8'hFF);
        add(8'h12, 8'hFF);
        add(8'h34, 8'hFF);
        add(8'h56, 8'hFF);
        run_txn("erase20", 0);
        tests++;
        if ({w2, w3} !== 2'b01) begin
            fails++;
            $display("FAIL commit_latency: got %b expected 01", {w2, w3});
        end
        add(8'h05, 8'hFF);
        add(8'h00, 8'h03);
        add(8'h00, 8'h03);
        run_txn("status_busy", 0);
        add(8'h04, 8'hFF);
        run_txn("wrdi_blocked", 0);
        add(8'h05, 8'hFF);
        add(8'h00, 8'h03);
        run_txn("status_after_wrdi", 0);
        serve_req("erase20");
        add(8'h05, 8'hFF);
        add(8'h00, 8'h00);
        run_txn("status_idle", 0);
    endtask

    task automatic test_erase_block;
        add(8'hD8, 8'hFF);
        add(8'h3F, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h00, 8'hFF);
        run_txn("eraseD8_nowel", 0);
        tests++;
        if (w3 !== 1'b0) begin
            fails++;
            $display("FAIL eraseD8_nowel: cmd_write got %b expected 0", w3);
        end
        add(8'h06, 8'hFF);
        run_txn("wren", 0);
        req_q.push_back({1'b1, 22'h07E000, 13'd8191});
        add(8'hD8, 8'hFF);
        add(8'h3F, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h00, 8'hFF);
        run_txn("eraseD8", 0);
        serve_req("eraseD8");
    endtask

    task automatic test_program;
        add(8'h06, 8'hFF);
        run_txn("wren", 0);
        add(8'h02, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h10, 8'hFF);
        run_txn("prog_nodata", 0);
        tests++;
        if (w3 !== 1'b0) begin
            fails++;
            $display("FAIL prog_nodata: cmd_write got %b expected 0", w3);
        end
        add(8'h05, 8'hFF);
        add(8'h00, 8'h02);
        run_txn("status_wel", 0);
        req_q.push_back({1'b0, 22'h000002, 13'd2});
        add(8'h02, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h10, 8'hFF);
        for (int i = 0; i < 20; i++) add(8'(i * 7 + 3), 8'hFF);
        run_txn("prog20", 0);
        serve_req("prog20");
        add(8'h06, 8'hFF);
        run_txn("wren", 0);
        req_q.push_back({1'b0, 22'h000246, 13'd31});
        add(8'h02, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h12, 8'hFF);
        add(8'h37, 8'hFF);
        for (int i = 0; i < 260; i++) add(8'($urandom_range(0, 255)), 8'hFF);
        run_txn("prog260", 0);
        serve_req("prog260");
    endtask

    task automatic test_abort;
        add(8'h06, 8'hFF);
        run_txn("wren", 0);
        add(8'h20, 8'hFF);
        add(8'h12, 8'hFF);
        add(8'h34, 8'hFF);
        run_txn("erase_short", 0);
        tests++;
        if (w3 !== 1'b0) begin
            fails++;
            $display("FAIL erase_short: cmd_write got %b expected 0", w3);
        end
        add(8'h20, 8'hFF);
        add(8'h12, 8'hFF);
        add(8'h34, 8'hFF);
        add(8'h56, 8'hFF);
        run_txn("erase_midbyte", 3);
        tests++;
        if (w3 !== 1'b0) begin
            fails++;
            $display("FAIL erase_midbyte: cmd_write got %b expected 0", w3);
        end
        run_txn("cs_no_sck", 0);
        tests++;
        if (w3 !== 1'b0 || log_q.size() != 0) begin
            fails++;
            $display("FAIL cs_no_sck: cmd_write %b pending log %0d expected 0 0", w3, log_q.size());
        end
        add(8'h05, 8'hFF);
        add(8'h00, 8'h02);
        run_txn("status_wel_kept", 0);
    endtask

    task automatic test_reset_mid;
        add(8'h20, 8'hFF);
        add(8'h12, 8'hFF);
        add(8'h34, 8'hFF);
        add(8'h56, 8'hFF);
        run_txn("erase_then_reset", 0);
        tests++;
        if (w3 !== 1'b1 || spi_write_addr !== 22'h024600) begin
            fails++;
            $display("FAIL erase_then_reset: cmd_write %b addr %06h expected 1 024600", w3, spi_write_addr);
        end
        #2 spi_write_done = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 tests++;
        if (spi_cmd_write !== 1'b0 || spi_write_addr !== 22'd0) begin
            fails++;
            $display("FAIL reset_mid: cmd_write %b addr %06h expected 0 000000", spi_cmd_write, spi_write_addr);
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 spi_write_done = 1'b1;
        add(8'h05, 8'hFF);
        add(8'h00, 8'h00);
        run_txn("status_after_reset", 0);
        add(8'h06, 8'hFF);
        run_txn("wren", 0);
        req_q.push_back({1'b1, 22'h07E000, 13'd8191});
        add(8'hD8, 8'hFF);
        add(8'h3F, 8'hFF);
        add(8'h00, 8'hFF);
        add(8'h00, 8'hFF);
        run_txn("eraseD8_after_reset", 0);
        serve_req("eraseD8_after_reset");
    endtask

    task automatic test_log_drain;
        repeat (20) @(posedge clk);
        #1 tests++;
        if (log_q.size() != 0 || log_strobe !== 1'b0) begin
            fails++;
            $display("FAIL log_drain: pending %0d strobe %b expected 0 0", log_q.size(), log_strobe);
        end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_erase_sector();
        test_erase_block();
        test_program();
        test_abort();
        test_reset_mid();
        test_log_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
